// File: rtl/mppc_gate_ctrl.sv
// Measurement-window controller for the MPPC dark counter.
// Opens a gate of GATE_TICKS x TICK_DIV cycles on start, counts rising hit edges
// while the gate is open, then latches the result for one LATCH cycle.
// Optional feature macro: HIT_SYNC_EN (2-FF synchronizer on hit plus history register).
module mppc_gate_ctrl #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned GATE_TICKS = 1000,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 cont_i,
    input  logic                 hit_i,
    output logic                 gate_o,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [CNT_WIDTH-1:0] count_out_o,
    output logic                 overflow_o
);

    localparam int unsigned CycW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TickW = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
    localparam logic [CycW-1:0]  CycLast  = CycW'(TICK_DIV - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(GATE_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StGate, StLatch} state_e;

    state_e               state_q, state_d;
    logic [CycW-1:0]      cyc_q, cyc_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
    logic                 ovf_out_q, ovf_out_d;
    logic                 strobe;
    logic [CNT_WIDTH-1:0] acc_hit;
    logic                 ovf_hit;
    logic                 gate_last;

`ifdef HIT_SYNC_EN
    // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2 (history for edge detection)
    logic [2:0] sync_q;

    // Two-flop synchronizer plus one history stage for the edge detector.
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], hit_i};
    end

    assign strobe = sync_q[1] & ~sync_q[2];
`else
    logic hit_d_q;

    // Single history register; hit is assumed synchronous to clk_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) hit_d_q <= 1'b0;
        else       hit_d_q <= hit_i;
    end

    assign strobe = hit_i & ~hit_d_q;
`endif

    assign gate_last = (tick_q == TickLast) && (cyc_q == CycLast);

    // Saturating accumulator value if this cycle's strobe is counted.
    always_comb begin
        acc_hit = acc_q;
        ovf_hit = ovf_q;
        if (strobe) begin
            if (&acc_q) ovf_hit = 1'b1;
            else        acc_hit = acc_q + CNT_WIDTH'(1);
        end
    end

    // Window sequencing: arm, count, latch, clear, optional re-arm.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        tick_d    = tick_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_out_d = cnt_out_q;
        ovf_out_d = ovf_out_q;
        unique case (state_q)
            StIdle: begin
                // stop wins over a simultaneous start
                if (start_i && !stop_i) begin
                    state_d = StGate;
                    cyc_d   = '0;
                    tick_d  = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StGate: begin
                if (stop_i) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end else if (gate_last) begin
                    // Result registers update on the edge that enters LATCH
                    state_d   = StLatch;
                    cnt_out_d = acc_hit;
                    ovf_out_d = ovf_hit;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                end else begin
                    acc_d = acc_hit;
                    ovf_d = ovf_hit;
                    if (cyc_q == CycLast) begin
                        cyc_d  = '0;
                        tick_d = tick_q + TickW'(1);
                    end else begin
                        cyc_d = cyc_q + CycW'(1);
                    end
                end
            end
            StLatch: begin
                if (cont_i && !stop_i) begin
                    state_d = StGate;
                    cyc_d   = '0;
                    tick_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            tick_q    <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            tick_q    <= tick_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_out_q <= cnt_out_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign gate_o      = (state_q == StGate);
    assign busy_o      = (state_q != StIdle);
    assign valid_o     = (state_q == StLatch);
    assign count_out_o = cnt_out_q;
    assign overflow_o  = ovf_out_q;

endmodule
